// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: opcodes, funcs, FSM states, flag
// positions and the coarse instruction classes used by writeback.
package alu_seq_pkg;
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam int ZF = 2;
    localparam int SF = 1;
    localparam int OF = 0;

    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

    typedef enum logic [2:0] {
        C_ALU_RD, C_ALU_RT, C_SLT_RD, C_SLT_RT,
        C_BRANCH, C_LOAD, C_STORE, C_NOP
    } iclass_t;
endpackage

// File: rtl/alu_instr_classify.sv
// Combinational decode of the instruction fields into writeback class,
// destination register index and whether signed overflow suppresses the write.
module alu_instr_classify
    import alu_seq_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       rt_idx,
    input  logic       rd_idx,
    output iclass_t    iclass,
    output logic       dest,
    output logic       ovf_checked
);
    always_comb begin
        iclass      = C_NOP;
        ovf_checked = 1'b0;
        case (opcode)
            OP_R: begin
                case (func)
                    F_ADD, F_SUB: begin
                        iclass      = C_ALU_RD;
                        ovf_checked = 1'b1;
                    end
                    F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLL, F_SLLV, F_SRL, F_SRLV, F_SRA, F_SRAV:
                        iclass = C_ALU_RD;
                    F_SLT, F_SLTU: iclass = C_SLT_RD;
                    default: iclass = C_NOP;
                endcase
            end
            OP_ADDI: begin
                iclass      = C_ALU_RT;
                ovf_checked = 1'b1;
            end
            OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: iclass = C_ALU_RT;
            OP_SLTI, OP_SLTIU:                  iclass = C_SLT_RT;
            OP_BEQ, OP_BNE:                     iclass = C_BRANCH;
            OP_LW:                              iclass = C_LOAD;
            OP_SW:                              iclass = C_STORE;
            default:                            iclass = C_NOP;
        endcase
    end

    assign dest = (iclass == C_ALU_RD || iclass == C_SLT_RD) ? rd_idx : rt_idx;
endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller owning gr0/gr1 and the PC; runs one instruction at a
// time through IDLE -> EXEC -> (MEM) -> WB against an external combinational ALU.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] GR0_INIT    = 32'h0000_0000,
    parameter logic [31:0] GR1_INIT    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [31:0] alu_instr,
    output logic [31:0] alu_gr0,
    output logic [31:0] alu_gr1,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] pc,
    output logic        retire,
    output logic        ovf_exc,
    output logic        mem_err,
    output logic [31:0] gr0_q,
    output logic [31:0] gr1_q
);
    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t      state, state_nx;
    logic [31:0] ir, res_q, rdata_q;
    logic [2:0]  flags_q;
    logic [7:0]  cnt;
    logic        timed_out;
    iclass_t     iclass;
    logic        dest, ovf_checked;
    logic        wr_en, taken, ovf_hit;
    logic [31:0] wr_data, pc_inc, br_tgt;

    alu_instr_classify u_classify (
        .opcode      (ir[31:26]),
        .func        (ir[5:0]),
        .rt_idx      (ir[16]),
        .rd_idx      (ir[11]),
        .iclass      (iclass),
        .dest        (dest),
        .ovf_checked (ovf_checked)
    );

    assign instr_ready = (state == IDLE);
    assign alu_instr   = (state == IDLE) ? 32'h0 : ir;
    assign alu_gr0     = gr0_q;
    assign alu_gr1     = gr1_q;
    assign mem_req     = (state == MEM);
    assign mem_we      = mem_req && (iclass == C_STORE);
    assign mem_addr    = res_q;
    assign mem_wdata   = ir[16] ? gr1_q : gr0_q;

    assign ovf_hit = ovf_checked && flags_q[OF];
    assign retire  = (state == WB);
    assign ovf_exc = retire && ovf_hit;
    assign mem_err = retire && timed_out;
    assign pc_inc  = pc + 32'd4;
    assign br_tgt  = pc_inc + {{14{ir[15]}}, ir[15:0], 2'b00};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (instr_valid) state_nx = EXEC;
            EXEC: state_nx = (iclass == C_LOAD || iclass == C_STORE) ? MEM : WB;
            MEM:  if (mem_ack || cnt == TIMEOUT) state_nx = WB;
            WB:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Writeback selection; branch sense comes from opcode bit 0 (beq=0, bne=1).
    always_comb begin
        wr_en   = 1'b0;
        wr_data = res_q;
        taken   = 1'b0;
        case (iclass)
            C_ALU_RD, C_ALU_RT: wr_en = !ovf_hit;
            C_SLT_RD, C_SLT_RT: begin
                wr_en   = 1'b1;
                wr_data = {31'b0, flags_q[SF]};
            end
            C_LOAD: begin
                wr_en   = !timed_out;
                wr_data = rdata_q;
            end
            C_BRANCH: taken = ir[26] ? !flags_q[ZF] : flags_q[ZF];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            gr0_q     <= GR0_INIT;
            gr1_q     <= GR1_INIT;
            ir        <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
            timed_out <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (instr_valid) begin
                    ir        <= instr;
                    timed_out <= 1'b0;
                end
                EXEC: begin
                    res_q   <= alu_result;
                    flags_q <= alu_flags;
                    cnt     <= 8'd1;
                end
                MEM: begin
                    if (mem_ack)             rdata_q   <= mem_rdata;
                    else if (cnt == TIMEOUT) timed_out <= 1'b1;
                    else                     cnt       <= cnt + 8'd1;
                end
                WB: begin
                    if (wr_en) begin
                        if (dest) gr1_q <= wr_data;
                        else      gr0_q <= wr_data;
                    end
                    pc <= taken ? br_tgt : pc_inc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU and memory responder, a table of
// instructions with hand-derived register/PC results, and a retire scoreboard.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] alu_instr, alu_gr0, alu_gr1, alu_result;
    logic [2:0]  alu_flags;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] pc, gr0_q, gr1_q;
    logic        retire, ovf_exc, mem_err;

    always #5 clk = ~clk;

    alu_sequencer #(
        .RESET_PC(32'h0), .GR0_INIT(32'h0), .GR1_INIT(32'h0), .MEM_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_instr(alu_instr), .alu_gr0(alu_gr0),
        .alu_gr1(alu_gr1), .alu_result(alu_result), .alu_flags(alu_flags),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc(pc), .retire(retire), .ovf_exc(ovf_exc), .mem_err(mem_err),
        .gr0_q(gr0_q), .gr1_q(gr1_q)
    );

    // Combinational ALU: returns {ZF,SF,OF, result}. For slt-style ops SF is the less-than result.
    function automatic logic [34:0] alu_model(input logic [31:0] i, input logic [31:0] g0, input logic [31:0] g1);
        logic [31:0] a, b, sx, zx, r;
        logic sf, of;
        a  = i[21] ? g1 : g0;
        b  = i[16] ? g1 : g0;
        sx = {{16{i[15]}}, i[15:0]};
        zx = {16'h0, i[15:0]};
        r = 32'h0; sf = 1'b0; of = 1'b0;
        case (i[31:26])
            6'b000000: case (i[5:0])
                6'h20, 6'h21: begin r = a + b; of = (a[31] == b[31]) && (r[31] != a[31]); end
                6'h22, 6'h23: begin r = a - b; of = (a[31] != b[31]) && (r[31] != a[31]); end
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h00: r = b << i[10:6];
                6'h04: r = b << a[4:0];
                6'h02: r = b >> i[10:6];
                6'h06: r = b >> a[4:0];
                6'h03: r = $signed(b) >>> i[10:6];
                6'h07: r = $signed(b) >>> a[4:0];
                6'h2A: begin r = a - b; sf = $signed(a) < $signed(b); end
                6'h2B: begin r = a - b; sf = a < b; end
                default: r = 32'h0;
            endcase
            6'b001000, 6'b001001: begin r = a + sx; of = (a[31] == sx[31]) && (r[31] != a[31]); end
            6'b100011, 6'b101011: r = a + sx;
            6'b001010: begin r = a - sx; sf = $signed(a) < $signed(sx); end
            6'b001011: begin r = a - sx; sf = a < sx; end
            6'b001100: r = a & zx;
            6'b001101: r = a | zx;
            6'b001110: r = a ^ zx;
            6'b000100, 6'b000101: r = a - b;
            default: r = 32'h0;
        endcase
        if (i[31:26] != 6'b001010 && i[31:26] != 6'b001011 &&
            !(i[31:26] == 6'b0 && (i[5:0] == 6'h2A || i[5:0] == 6'h2B)))
            sf = r[31];
        return {(r == 32'h0), sf, of, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_model(alu_instr, alu_gr0, alu_gr1);

    typedef struct {
        logic [31:0] instr;
        int          dly;     // MEM cycles before ack; -1 = never ack
        logic [31:0] rdata;
        logic [31:0] g0, g1, pc;
        logic        ovf, merr;
        int          mcyc;
        logic [31:0] addr;
    } vec_t;

    vec_t vt[$];
    vec_t sbq[$];
    vec_t pend_e;
    bit   pend = 1'b0;
    int   nvec = 0, nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: flags checked in the retire cycle, architectural state one cycle later.
    always @(negedge clk) begin
        if (pend) begin
            chk("gr0", gr0_q, pend_e.g0);
            chk("gr1", gr1_q, pend_e.g1);
            chk("pc", pc, pend_e.pc);
            pend = 1'b0;
        end
        if (rst_n && retire) begin
            if (sbq.size() == 0) chk("unexpected_retire", 32'(retire), 32'h0);
            else begin
                pend_e = sbq.pop_front();
                chk("ovf_exc", 32'(ovf_exc), 32'(pend_e.ovf));
                chk("mem_err", 32'(mem_err), 32'(pend_e.merr));
                pend = 1'b1;
            end
        end
    end

    task automatic issue(input vec_t v);
        int n, mc;
        n = 0;
        while (!instr_ready && n < 50) begin @(negedge clk); n++; end
        chk("ready_wait", 32'(instr_ready), 32'h1);
        sbq.push_back(v);
        instr_valid = 1'b1;
        instr       = v.instr;
        @(negedge clk);
        instr_valid = 1'b0;
        n = 1; mc = 0;
        while (!retire && n < 60) begin
            if (mem_req) begin
                mc++;
                if (mc == 1) begin
                    chk("mem_addr", mem_addr, v.addr);
                    chk("mem_we", 32'(mem_we), 32'(v.instr[31:26] == 6'b101011));
                    if (v.instr[31:26] == 6'b101011)
                        chk("mem_wdata", mem_wdata, v.instr[16] ? v.g1 : v.g0);
                end
                mem_ack   = (v.dly >= 0) && (mc == v.dly + 1);
                mem_rdata = v.rdata;
            end else mem_ack = 1'b0;
            @(negedge clk);
            n++;
        end
        mem_ack = 1'b0;
        chk("retire_seen", 32'(retire), 32'h1);
        chk("latency", 32'(n), 32'(2 + mc));
        chk("mem_cycles", 32'(mc), 32'(v.mcyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                instr        dly  rdata         g0            g1            pc      ovf merr mcyc addr
        vt.push_back('{32'h20010005, 0,  32'h0, 32'h00000000, 32'h00000005, 32'h04, 0, 0, 0, 32'h0}); // addi $1,$0,5
        vt.push_back('{32'h34007FFF, 0,  32'h0, 32'h00007FFF, 32'h00000005, 32'h08, 0, 0, 0, 32'h0}); // ori
        vt.push_back('{32'h00000400, 0,  32'h0, 32'h7FFF0000, 32'h00000005, 32'h0C, 0, 0, 0, 32'h0}); // sll 16
        vt.push_back('{32'h3400FFFF, 0,  32'h0, 32'h7FFFFFFF, 32'h00000005, 32'h10, 0, 0, 0, 32'h0}); // ori
        vt.push_back('{32'h00010020, 0,  32'h0, 32'h7FFFFFFF, 32'h00000005, 32'h14, 1, 0, 0, 32'h0}); // add ovf
        vt.push_back('{32'h00010021, 0,  32'h0, 32'h80000004, 32'h00000005, 32'h18, 0, 0, 0, 32'h0}); // addu
        vt.push_back('{32'h00010822, 0,  32'h0, 32'h80000004, 32'h00000005, 32'h1C, 1, 0, 0, 32'h0}); // sub ovf
        vt.push_back('{32'h0001082A, 0,  32'h0, 32'h80000004, 32'h00000001, 32'h20, 0, 0, 0, 32'h0}); // slt
        vt.push_back('{32'h0001082B, 0,  32'h0, 32'h80000004, 32'h00000000, 32'h24, 0, 0, 0, 32'h0}); // sltu
        vt.push_back('{32'h38210003, 0,  32'h0, 32'h80000004, 32'h00000003, 32'h28, 0, 0, 0, 32'h0}); // xori
        vt.push_back('{32'h30000003, 0,  32'h0, 32'h00000000, 32'h00000003, 32'h2C, 0, 0, 0, 32'h0}); // andi
        vt.push_back('{32'h34000003, 0,  32'h0, 32'h00000003, 32'h00000003, 32'h30, 0, 0, 0, 32'h0}); // ori
        vt.push_back('{32'h10010002, 0,  32'h0, 32'h00000003, 32'h00000003, 32'h3C, 0, 0, 0, 32'h0}); // beq taken
        vt.push_back('{32'h14010002, 0,  32'h0, 32'h00000003, 32'h00000003, 32'h40, 0, 0, 0, 32'h0}); // bne not taken
        vt.push_back('{32'h1001FFFC, 0,  32'h0, 32'h00000003, 32'h00000003, 32'h34, 0, 0, 0, 32'h0}); // beq back
        vt.push_back('{32'hFC000000, 0,  32'h0, 32'h00000003, 32'h00000003, 32'h38, 0, 0, 0, 32'h0}); // bad opcode
        vt.push_back('{32'h0000003F, 0,  32'h0, 32'h00000003, 32'h00000003, 32'h3C, 0, 0, 0, 32'h0}); // bad func
        vt.push_back('{32'h2801FFFF, 0,  32'h0, 32'h00000003, 32'h00000000, 32'h40, 0, 0, 0, 32'h0}); // slti
        vt.push_back('{32'h2C01FFFF, 0,  32'h0, 32'h00000003, 32'h00000001, 32'h44, 0, 0, 0, 32'h0}); // sltiu
        vt.push_back('{32'h30000000, 0,  32'h0, 32'h00000000, 32'h00000001, 32'h48, 0, 0, 0, 32'h0}); // andi 0
        vt.push_back('{32'h34000100, 0,  32'h0, 32'h00000100, 32'h00000001, 32'h4C, 0, 0, 0, 32'h0}); // ori 0x100
        vt.push_back('{32'h8C010004, 3,  32'hDEADBEEF, 32'h00000100, 32'hDEADBEEF, 32'h50, 0, 0, 4,  32'h104}); // lw
        vt.push_back('{32'hAC010008, -1, 32'h0, 32'h00000100, 32'hDEADBEEF, 32'h54, 0, 1, 16, 32'h108}); // sw timeout
        vt.push_back('{32'hAC010008, 0,  32'h0, 32'h00000100, 32'hDEADBEEF, 32'h58, 0, 0, 1,  32'h108}); // sw acked
        vt.push_back('{32'h8C000004, -1, 32'hCAFEF00D, 32'h00000100, 32'hDEADBEEF, 32'h5C, 0, 1, 16, 32'h104}); // lw timeout
        vt.push_back('{32'h8C000000, 15, 32'h12345678, 32'h12345678, 32'hDEADBEEF, 32'h60, 0, 0, 16, 32'h100}); // ack at limit

        rst_n = 1'b0; instr_valid = 1'b0; instr = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'h1);
        chk("rst_pc", pc, 32'h0);
        chk("rst_gr0", gr0_q, 32'h0);
        chk("rst_gr1", gr1_q, 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_alu_instr", alu_instr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vt[i]) issue(vt[i]);

        // Stray ack while idle must not start anything.
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_ready", 32'(instr_ready), 32'h1);
        chk("idle_ack_pc", pc, 32'h60);

        // Reset in the middle of a load: abort without writeback or retire.
        instr_valid = 1'b1; instr = 32'h8C010000;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_mem_req", 32'(mem_req), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", 32'(mem_req), 32'h0);
        chk("abort_retire", 32'(retire), 32'h0);
        chk("abort_pc", pc, 32'h0);
        chk("abort_gr1", gr1_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(instr_ready), 32'h1);
        chk("post_rst_gr0", gr0_q, 32'h0);
        issue('{32'h20010005, 0, 32'h0, 32'h0, 32'h5, 32'h4, 0, 0, 0, 32'h0});
        @(negedge clk);
        chk("ready_T3", 32'(instr_ready), 32'h1);
        @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller that owns the two-entry general register file (gr0/gr1) and the program counter.
- Accepts one MIPS instruction at a time over a valid/ready handshake. Drives the combinational ALU's instruction and register inputs, then samples its result and flags {ZF,SF,OF}.
- Sequences memory access for lw/sw, writes results back and resolves beq/bne.
- Sits between the instruction source and the ALU/data-memory port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- GR0_INIT, 32'h0000_0000, gr0 value after reset.
- GR1_INIT, 32'h0000_0000, gr1 value after reset.
- MEM_TIMEOUT, 16, maximum cycles in MEM waiting for mem_ack (range 1..255).

Ports:
- clk  in  1  single clock, all state rises on posedge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr  in  32  MIPS instruction word.
- instr_ready  out  1  sequencer can accept (high only in IDLE).
- alu_instr  out  32  instruction presented to ALU.
- alu_gr0  out  32  gr0 value presented to ALU.
- alu_gr1  out  32  gr1 value presented to ALU.
- alu_result  in  32  ALU result.
- alu_flags  in  3  ALU flags {ZF,SF,OF}.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req.
- mem_addr  out  32  captured ALU result.
- mem_wdata  out  32  rt register value (store).
- mem_rdata  in  32  load data, valid with mem_ack.
- mem_ack  in  1  one-cycle memory completion.
- pc  out  32  current PC.
- retire  out  1  one-cycle pulse per completed instruction.
- ovf_exc  out  1  one-cycle pulse, overflow suppressed writeback.
- mem_err  out  1  one-cycle pulse, memory timeout.
- gr0_q  out  32  architectural gr0.
- gr1_q  out  32  architectural gr1.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, gr0/gr1=GR*_INIT.
  - All pulses, mem_req and mem_we = 0; captured instr/result/flags = 0.
  - Reset in any state aborts the instruction: no writeback, no retire.
- Register index = bit 0 of the 5-bit field: rs=instr[21], rt=instr[16], rd=instr[11].
- alu_gr0/alu_gr1 always equal gr0_q/gr1_q. alu_instr = captured instruction (0 in IDLE).
- FSM states: IDLE -> EXEC -> {MEM ->} WB -> IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, capture instr and go to EXEC.
- EXEC (1 cycle):
  - ALU settles on the captured instruction; capture alu_result and alu_flags at the end of the cycle.
  - lw/sw go to MEM; all others go to WB.
- MEM:
  - mem_req=1; mem_addr = captured result; mem_we=1 for sw; mem_wdata = rt value.
  - On mem_ack: capture mem_rdata, go to WB.
  - Cycle counter starts at 1 on MEM entry. Not acked after MEM_TIMEOUT cycles: go to WB with the error marked.
  - mem_ack in the same cycle as timeout counts as ack.
- WB (1 cycle, retire=1):
  - R-type ALU ops (add/addu/sub/subu/and/or/xor/nor/sll/sllv/srl/srlv/sra/srav) write result to rd.
  - addi/addiu/andi/ori/xori write result to rt.
  - slt/sltu write {31'b0,SF} to rd; slti/sltiu write {31'b0,SF} to rt.
  - add/sub/addi with OF=1: no write, ovf_exc=1.
  - lw writes mem data to rt; on timeout no write and mem_err=1. sw writes nothing.
  - beq taken iff ZF=1; bne taken iff ZF=0.
  - Taken branch: pc <= pc+4+(sext(imm)<<2). Otherwise pc <= pc+4, 32-bit wrap-around.
  - Unknown opcode/func: NOP, pc+4, retire.
- Latency:
  - Non-memory instruction: accept edge T, EXEC T+1, WB T+2, instr_ready again at T+3.
  - Memory instruction: adds 1..MEM_TIMEOUT MEM cycles.
- Other rules:
  - instr_valid is ignored outside IDLE.
  - mem_ack outside MEM is ignored.
  - Writes to gr0/gr1 take effect at the end of WB.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants (R=000000, addi=001000, addiu=001001, beq=000100, bne=000101, slti=001010, sltiu=001011, andi=001100, ori=001101, xori=001110, lw=100011, sw=101011);
  - func constants;
  - state enum {IDLE,EXEC,MEM,WB};
  - flag indices ZF=2, SF=1, OF=0;
  - instr-class enum {C_ALU_RD,C_ALU_RT,C_SLT_RD,C_SLT_RT,C_BRANCH,C_LOAD,C_STORE,C_NOP}.
- One sub-module, alu_instr_classify (combinational): instr -> class, dest index, ovf_checked bit.

Test Plan:
- Reset, gr0=0, gr1=0. Issue addi $1,$0,0x0005 (0x20010005) -> gr1=5 at T+3, retire pulses at T+2, pc=4.
- GR0_INIT=GR1_INIT=0x7FFFFFFF, add $0,$0,$1 -> ovf_exc=1, gr0 unchanged 0x7FFFFFFF, pc+4.
- gr0=gr1=3, pc=0x10, beq $0,$1,+2 (0x10010002) -> pc=0x1C. Same with bne -> pc=0x14.
- gr0=0x100, lw $1,4($0), mem_ack with rdata=0xDEADBEEF 3 cycles after mem_req -> mem_addr=0x104, mem_we=0, gr1=0xDEADBEEF, retire once.
- sw with no mem_ack, MEM_TIMEOUT=16 -> mem_req high exactly 16 cycles, mem_err pulse, pc+4, regs unchanged.
- Deassert rst_n mid-MEM -> mem_req drops immediately, pc=RESET_PC, no retire; instr_ready=1 after release.
